// File: rtl/bash_hash_params_pkg.sv
// Shared parameters and types for the bash_hash core and its sponge controller.
package bash_hash_params_pkg;

    localparam int unsigned SLEN     = 64;
    localparam int unsigned ROUNDS   = 24;
    localparam logic [7:0]  PAD_BYTE = 8'h40;

    typedef enum logic [1:0] {
        Level128 = 2'd0,
        Level192 = 2'd1,
        Level256 = 2'd2
    } bash_level_e;

    typedef enum logic [2:0] {
        StIdle,
        StPrep,
        StFill,
        StStart,
        StWork,
        StOut
    } ctrl_state_e;

    // Sponge rate in SLEN-bit words for a security level.
    function automatic logic [4:0] rate_words(input bash_level_e level);
        logic [4:0] r;
        case (level)
            Level128: r = 5'd16;
            Level192: r = 5'd12;
            default:  r = 5'd8;
        endcase
        return r;
    endfunction

    // Digest length in SLEN-bit words (2l bits) for a security level.
    function automatic logic [3:0] digest_words(input bash_level_e level);
        logic [3:0] d;
        case (level)
            Level128: d = 4'd4;
            Level192: d = 4'd6;
            default:  d = 4'd8;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bash_pad_word.sv
// Applies Bash padding to the final message word.
// Build option BASH_HASH_CTRL_BYTE_EN: honour byte counts 0..8; otherwise only an
// empty tail (n=0) is padded in place and any other count means a full word.
module bash_pad_word
    import bash_hash_params_pkg::*;
(
    input  logic [SLEN-1:0] i_word,
    input  logic [3:0]      i_n,
    input  logic            i_pad_here,
    output logic [SLEN-1:0] o_word
);

    // Keep bytes below n, place the pad byte at n, zero everything above.
    always_comb begin
        o_word = i_word;
        if (i_pad_here) begin
`ifdef BASH_HASH_CTRL_BYTE_EN
            for (int b = 0; b < 8; b++) begin
                if (4'(b) == i_n) begin
                    o_word[8*b +: 8] = PAD_BYTE;
                end else if (4'(b) > i_n) begin
                    o_word[8*b +: 8] = 8'h00;
                end
            end
`else
            if (i_n == 4'd0) begin
                o_word = {{(SLEN-8){1'b0}}, PAD_BYTE};
            end
`endif
        end
    end

endmodule

// File: rtl/bash_hash_ctrl.sv
// Sponge controller for the bash_hash core: packs the message stream into rate
// blocks, pads, sequences prep/start/work/first and streams the digest.
// Build option BASH_HASH_CTRL_BYTE_EN enables byte-granular tails.
module bash_hash_ctrl
    import bash_hash_params_pkg::*;
#(
    parameter int unsigned Rounds = ROUNDS
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            init_i,
    input  bash_level_e     level_i,
    input  logic            msg_valid_i,
    output logic            msg_ready_o,
    input  logic [SLEN-1:0] msg_data_i,
    input  logic            msg_last_i,
    input  logic [3:0]      msg_bytes_i,
    output logic            prep_o,
    output logic            start_o,
    output logic            work_o,
    output logic            first_o,
    output bash_level_e     l_o,
    output logic [SLEN-1:0] x0_o,
    output logic [SLEN-1:0] x1_o,
    output logic [SLEN-1:0] x2_o,
    output logic [SLEN-1:0] x3_o,
    output logic [SLEN-1:0] x4_o,
    output logic [SLEN-1:0] x5_o,
    output logic [SLEN-1:0] x6_o,
    output logic [SLEN-1:0] x7_o,
    output logic [SLEN-1:0] x8_o,
    output logic [SLEN-1:0] x9_o,
    output logic [SLEN-1:0] x10_o,
    output logic [SLEN-1:0] x11_o,
    output logic [SLEN-1:0] x12_o,
    output logic [SLEN-1:0] x13_o,
    output logic [SLEN-1:0] x14_o,
    output logic [SLEN-1:0] x15_o,
    input  logic [SLEN-1:0] y0_i,
    input  logic [SLEN-1:0] y1_i,
    input  logic [SLEN-1:0] y2_i,
    input  logic [SLEN-1:0] y3_i,
    input  logic [SLEN-1:0] y4_i,
    input  logic [SLEN-1:0] y5_i,
    input  logic [SLEN-1:0] y6_i,
    input  logic [SLEN-1:0] y7_i,
    output logic            dig_valid_o,
    input  logic            dig_ready_i,
    output logic [SLEN-1:0] dig_data_o,
    output logic            dig_last_o,
    output logic            busy_o
);

    localparam logic [SLEN-1:0] PAD_WORD = {{(SLEN-8){1'b0}}, PAD_BYTE};

    ctrl_state_e     r_state;
    ctrl_state_e     w_state_next;
    bash_level_e     r_level;
    logic [SLEN-1:0] r_buf [16];
    logic [3:0]      r_widx;
    logic [4:0]      r_rnd;
    logic [3:0]      r_k;
    logic            r_pad_pend;  // 0x40 owed to word 0 of the next block
    logic            r_final;     // block being processed is the last of the hash
    logic            r_first_blk;

    logic [SLEN-1:0] w_y [8];
    logic [SLEN-1:0] w_pad_word;
    logic [4:0]      w_rate;
    logic [3:0]      w_dig;
    logic [4:0]      w_next_idx;
    logic            w_accept;
    logic            w_blk_full;
    logic            w_tail_full;
    logic            w_rnd_done;
    logic            w_dig_last;

    assign w_y[0] = y0_i;
    assign w_y[1] = y1_i;
    assign w_y[2] = y2_i;
    assign w_y[3] = y3_i;
    assign w_y[4] = y4_i;
    assign w_y[5] = y5_i;
    assign w_y[6] = y6_i;
    assign w_y[7] = y7_i;

    assign x0_o  = r_buf[0];
    assign x1_o  = r_buf[1];
    assign x2_o  = r_buf[2];
    assign x3_o  = r_buf[3];
    assign x4_o  = r_buf[4];
    assign x5_o  = r_buf[5];
    assign x6_o  = r_buf[6];
    assign x7_o  = r_buf[7];
    assign x8_o  = r_buf[8];
    assign x9_o  = r_buf[9];
    assign x10_o = r_buf[10];
    assign x11_o = r_buf[11];
    assign x12_o = r_buf[12];
    assign x13_o = r_buf[13];
    assign x14_o = r_buf[14];
    assign x15_o = r_buf[15];

    assign l_o        = r_level;
    assign busy_o     = (r_state != StIdle);
    assign w_rate     = rate_words(r_level);
    assign w_dig      = digest_words(r_level);
    assign w_accept   = (r_state == StFill) && msg_valid_i;
    assign w_next_idx = {1'b0, r_widx} + 5'd1;
    assign w_blk_full = (w_next_idx == w_rate);
    assign w_rnd_done = (r_rnd == 5'(Rounds - 1));
    assign w_dig_last = (r_state == StOut) && (r_k == w_dig - 4'd1);

`ifdef BASH_HASH_CTRL_BYTE_EN
    assign w_tail_full = (msg_bytes_i >= 4'd8);
`else
    assign w_tail_full = (msg_bytes_i != 4'd0);
`endif

    bash_pad_word u_pad (
        .i_word     (msg_data_i),
        .i_n        (msg_bytes_i),
        .i_pad_here (msg_last_i),
        .o_word     (w_pad_word)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and per-state outputs.
    always_comb begin
        w_state_next = r_state;
        prep_o       = 1'b0;
        start_o      = 1'b0;
        work_o       = 1'b0;
        first_o      = 1'b0;
        msg_ready_o  = 1'b0;
        dig_valid_o  = 1'b0;
        dig_last_o   = 1'b0;
        dig_data_o   = '0;
        unique case (r_state)
            StIdle: begin
                if (init_i) w_state_next = StPrep;
            end
            StPrep: begin
                prep_o       = 1'b1;
                w_state_next = StFill;
            end
            StFill: begin
                msg_ready_o = 1'b1;
                if (w_accept && (msg_last_i || w_blk_full)) w_state_next = StStart;
            end
            StStart: begin
                start_o      = 1'b1;
                w_state_next = StWork;
            end
            StWork: begin
                work_o  = 1'b1;
                first_o = r_first_blk && (r_rnd == 5'd0);
                if (w_rnd_done) begin
                    // A pending pad after a full final-data block needs one more block.
                    if (r_final)         w_state_next = StOut;
                    else if (r_pad_pend) w_state_next = StStart;
                    else                 w_state_next = StFill;
                end
            end
            StOut: begin
                dig_valid_o = 1'b1;
                dig_data_o  = w_y[r_k[2:0]];
                dig_last_o  = w_dig_last;
                if (dig_ready_i && w_dig_last) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase
    end

    // Datapath: buffer fill and padding, round and digest counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_level     <= Level128;
            r_widx      <= '0;
            r_rnd       <= '0;
            r_k         <= '0;
            r_pad_pend  <= 1'b0;
            r_final     <= 1'b0;
            r_first_blk <= 1'b0;
            for (int i = 0; i < 16; i++) r_buf[i] <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (init_i) begin
                        r_level     <= level_i;
                        r_first_blk <= 1'b1;
                        r_final     <= 1'b0;
                        r_pad_pend  <= 1'b0;
                        r_widx      <= '0;
                        r_rnd       <= '0;
                        r_k         <= '0;
                    end
                end
                StFill: begin
                    if (w_accept) begin
                        r_buf[r_widx] <= w_pad_word;
                        r_widx        <= r_widx + 4'd1;
                        if (msg_last_i) begin
                            if (!w_tail_full) begin
                                r_final <= 1'b1;
                            end else if (w_blk_full) begin
                                r_pad_pend <= 1'b1;
                            end else begin
                                r_buf[r_widx + 4'd1] <= PAD_WORD;
                                r_final              <= 1'b1;
                            end
                        end
                    end
                end
                StStart: begin
                    // The core samples x at this edge, so clearing here is free zero fill.
                    for (int i = 0; i < 16; i++) r_buf[i] <= '0;
                    r_widx <= '0;
                    if (r_final) begin
                        r_pad_pend <= 1'b0;
                    end else if (r_pad_pend) begin
                        r_buf[0] <= PAD_WORD;
                    end
                end
                StWork: begin
                    if (w_rnd_done) begin
                        r_rnd       <= '0;
                        r_first_blk <= 1'b0;
                        if (!r_final && r_pad_pend) r_final <= 1'b1;
                    end else begin
                        r_rnd <= r_rnd + 5'd1;
                    end
                end
                StOut: begin
                    if (dig_ready_i) r_k <= w_dig_last ? 4'd0 : r_k + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bash_hash_ctrl.sv
// Directed, table-driven bench for bash_hash_ctrl.
module tb_bash_hash_ctrl;
    import bash_hash_params_pkg::*;

    typedef struct {
        bash_level_e lv;
        int          nw;
        logic [3:0]  nb;
        logic [63:0] tail;
        logic [63:0] exp_tail;
        logic [63:0] exp_after;
        int          blocks;
        bit          pad_only;
        int          d;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        init_i;
    bash_level_e level_i;
    logic        msg_valid_i;
    logic        msg_ready_o;
    logic [63:0] msg_data_i;
    logic        msg_last_i;
    logic [3:0]  msg_bytes_i;
    logic        prep_o, start_o, work_o, first_o;
    bash_level_e l_o;
    logic [63:0] x_w [16];
    logic [63:0] y_w [8];
    logic        dig_valid_o;
    logic        dig_ready_i;
    logic [63:0] dig_data_o;
    logic        dig_last_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int n_start = 0, n_work = 0, n_first = 0, n_prep = 0, bad_first = 0;
    int start_cyc = 0, work_first_cyc = 0, work_last_cyc = 0;
    logic prev_work = 1'b0;
    logic [63:0] x_cap [16];

    vec_t tbl [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bash_hash_ctrl dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .init_i      (init_i),
        .level_i     (level_i),
        .msg_valid_i (msg_valid_i),
        .msg_ready_o (msg_ready_o),
        .msg_data_i  (msg_data_i),
        .msg_last_i  (msg_last_i),
        .msg_bytes_i (msg_bytes_i),
        .prep_o      (prep_o),
        .start_o     (start_o),
        .work_o      (work_o),
        .first_o     (first_o),
        .l_o         (l_o),
        .x0_o        (x_w[0]),
        .x1_o        (x_w[1]),
        .x2_o        (x_w[2]),
        .x3_o        (x_w[3]),
        .x4_o        (x_w[4]),
        .x5_o        (x_w[5]),
        .x6_o        (x_w[6]),
        .x7_o        (x_w[7]),
        .x8_o        (x_w[8]),
        .x9_o        (x_w[9]),
        .x10_o       (x_w[10]),
        .x11_o       (x_w[11]),
        .x12_o       (x_w[12]),
        .x13_o       (x_w[13]),
        .x14_o       (x_w[14]),
        .x15_o       (x_w[15]),
        .y0_i        (y_w[0]),
        .y1_i        (y_w[1]),
        .y2_i        (y_w[2]),
        .y3_i        (y_w[3]),
        .y4_i        (y_w[4]),
        .y5_i        (y_w[5]),
        .y6_i        (y_w[6]),
        .y7_i        (y_w[7]),
        .dig_valid_o (dig_valid_o),
        .dig_ready_i (dig_ready_i),
        .dig_data_o  (dig_data_o),
        .dig_last_o  (dig_last_o),
        .busy_o      (busy_o)
    );

    // Control-pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_ni) begin
            if (start_o) begin
                n_start++;
                start_cyc = cyc;
                for (int j = 0; j < 16; j++) x_cap[j] = x_w[j];
            end
            if (work_o) begin
                n_work++;
                if (!prev_work) work_first_cyc = cyc;
                work_last_cyc = cyc;
            end
            if (first_o) begin
                n_first++;
                if (!work_o) bad_first++;
            end
            if (prep_o) n_prep++;
            prev_work = work_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'hA5A5_0000_0000_0000 + 64'(i);
    endfunction

    function automatic int rate_of(input bash_level_e lv);
        return (lv == Level128) ? 16 : (lv == Level192) ? 12 : 8;
    endfunction

    task automatic run_vec(input vec_t v, input int stall);
        int s_start, s_work, s_first, s_prep, s_bad;
        int t_acc, t_dv, guard, r, idx, bstart;
        logic [63:0] e [16];
        s_start = n_start; s_work = n_work; s_first = n_first;
        s_prep = n_prep; s_bad = bad_first;
        t_acc = 0;
        level_i = v.lv;
        init_i  = 1'b1;
        tick();
        init_i = 1'b0;
        check("prep_at_t+1", prep_o, 1);
        check("level_latched", 64'(l_o), 64'(v.lv));
        tick();
        check("ready_at_t+2", msg_ready_o, 1);
        for (int i = 0; i < v.nw; i++) begin
            msg_valid_i = 1'b1;
            msg_last_i  = (i == v.nw - 1);
            msg_data_i  = (i == v.nw - 1) ? v.tail : pat(i);
            msg_bytes_i = (i == v.nw - 1) ? v.nb : 4'd8;
            guard = 0;
            while (!msg_ready_o && guard < 100) begin
                tick();
                guard++;
            end
            if (!msg_ready_o) check("ready_timeout", msg_ready_o, 1);
            t_acc = cyc;
            tick();
        end
        msg_valid_i = 1'b0;
        msg_last_i  = 1'b0;
        guard = 0;
        while (!dig_valid_o && guard < 200) begin
            tick();
            guard++;
        end
        t_dv = cyc;
        check("dig_valid_seen", dig_valid_o, 1);
        if (!v.pad_only) begin
            check("start_at_t+1", 64'(start_cyc), 64'(t_acc + 1));
            check("work_from_t+2", 64'(work_first_cyc), 64'(t_acc + 2));
            check("work_to_t+25", 64'(work_last_cyc), 64'(t_acc + 25));
            check("dig_valid_at_t+26", 64'(t_dv), 64'(t_acc + 26));
        end
        dig_ready_i = 1'b0;
        for (int s = 0; s < stall; s++) begin
            check("stall_data_y0", dig_data_o, y_w[0]);
            check("stall_valid", dig_valid_o, 1);
            tick();
        end
        dig_ready_i = 1'b1;
        for (int k = 0; k < v.d; k++) begin
            check("dig_data", dig_data_o, y_w[k]);
            check("dig_last", dig_last_o, (k == v.d - 1));
            check("dig_valid", dig_valid_o, 1);
            tick();
        end
        dig_ready_i = 1'b0;
        check("idle_after_digest", busy_o, 0);
        check("no_valid_after_digest", dig_valid_o, 0);
        check("start_count", 64'(n_start - s_start), 64'(v.blocks));
        check("work_count", 64'(n_work - s_work), 64'(24 * v.blocks));
        check("first_count", 64'(n_first - s_first), 1);
        check("prep_count", 64'(n_prep - s_prep), 1);
        check("first_outside_work", 64'(bad_first - s_bad), 0);
        r      = rate_of(v.lv);
        idx    = (v.nw - 1) % r;
        bstart = ((v.nw - 1) / r) * r;
        for (int j = 0; j < 16; j++) e[j] = 64'h0;
        if (v.pad_only) begin
            e[0] = 64'h40;
        end else begin
            for (int j = 0; j < idx; j++) e[j] = pat(bstart + j);
            e[idx] = v.exp_tail;
            if (idx + 1 < 16) e[idx + 1] = v.exp_after;
        end
        for (int j = 0; j < 16; j++) check($sformatf("final_x%0d", j), x_cap[j], e[j]);
    endtask

    initial begin
        int guard;
        tbl[0] = '{Level256, 1, 4'd0, 64'hDEAD_BEEF_0000_0000, 64'h40, 64'h0, 1, 1'b0, 8};
        tbl[1] = '{Level128, 16, 4'd8, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF,
                   64'h0, 2, 1'b1, 4};
`ifdef BASH_HASH_CTRL_BYTE_EN
        tbl[2] = '{Level192, 3, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_40FF_FFFF_FFFF,
                   64'h0, 1, 1'b0, 6};
        tbl[3] = '{Level256, 8, 4'd3, 64'h8877_6655_4433_2211, 64'h0000_0000_4033_2211,
                   64'h0, 1, 1'b0, 8};
        tbl[7] = '{Level192, 12, 4'd7, 64'h1122_3344_5566_7788, 64'h4022_3344_5566_7788,
                   64'h0, 1, 1'b0, 6};
`else
        tbl[2] = '{Level192, 3, 4'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   64'h40, 1, 1'b0, 6};
        tbl[3] = '{Level256, 8, 4'd3, 64'h8877_6655_4433_2211, 64'h8877_6655_4433_2211,
                   64'h0, 2, 1'b1, 8};
        tbl[7] = '{Level192, 12, 4'd7, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788,
                   64'h0, 2, 1'b1, 6};
`endif
        tbl[4] = '{Level192, 12, 4'd8, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210,
                   64'h0, 2, 1'b1, 6};
        tbl[5] = '{Level128, 20, 4'd0, 64'h5555_5555_5555_5555, 64'h40, 64'h0, 2, 1'b0, 4};
        tbl[6] = '{Level256, 2, 4'd8, 64'h0F0E_0D0C_0B0A_0908, 64'h0F0E_0D0C_0B0A_0908,
                   64'h40, 1, 1'b0, 8};

        for (int j = 0; j < 8; j++) y_w[j] = {32'hC0FF_EE00 + 32'(j), 32'h600D_0000 + 32'(j)};
        rst_ni = 1'b0; init_i = 1'b0; level_i = Level128; msg_valid_i = 1'b0;
        msg_data_i = '0; msg_last_i = 1'b0; msg_bytes_i = '0; dig_ready_i = 1'b0;

        #3;
        check("rst_busy", busy_o, 0);
        check("rst_prep", prep_o, 0);
        check("rst_start", start_o, 0);
        check("rst_work", work_o, 0);
        check("rst_first", first_o, 0);
        check("rst_ready", msg_ready_o, 0);
        check("rst_dig_valid", dig_valid_o, 0);
        check("rst_dig_last", dig_last_o, 0);
        check("rst_dig_data", dig_data_o, 0);
        check("rst_x0", x_w[0], 0);
        check("rst_x15", x_w[15], 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // Message beats while idle are ignored.
        msg_valid_i = 1'b1; msg_last_i = 1'b1; msg_data_i = 64'h1234;
        tick();
        tick();
        check("idle_ignores_valid_busy", busy_o, 0);
        check("idle_ready_low", msg_ready_o, 0);
        msg_valid_i = 1'b0; msg_last_i = 1'b0;
        tick();

        run_vec(tbl[0], 10);
        for (int i = 1; i < 8; i++) run_vec(tbl[i], 0);

        // Reset during WORK aborts the hash, then a fresh empty-message run.
        level_i = Level256; init_i = 1'b1;
        tick();
        init_i = 1'b0;
        tick();
        msg_valid_i = 1'b1; msg_last_i = 1'b1; msg_bytes_i = 4'd0;
        tick();
        msg_valid_i = 1'b0; msg_last_i = 1'b0;
        guard = 0;
        while (!work_o && guard < 50) begin
            tick();
            guard++;
        end
        check("work_reached", work_o, 1);
        tick();
        tick();
        rst_ni = 1'b0;
        #1;
        check("midrst_busy", busy_o, 0);
        check("midrst_work", work_o, 0);
        check("midrst_ready", msg_ready_o, 0);
        check("midrst_dig_valid", dig_valid_o, 0);
        check("midrst_level", 64'(l_o), 64'(Level128));
        tick();
        rst_ni = 1'b1;
        tick();
        run_vec(tbl[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
